// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the fetch/prefetch unit: size defaults, FSM
// encodings and a PC alignment helper.
package cpu_fetch_pkg;

  localparam int IMEM_AW_DEF = 6;
  localparam int QDEPTH_DEF  = 2;

  // FETCH: reading bytes from instruction memory.
  // HOLD:  a complete word is parked because the queue is full.
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  // Instructions are word aligned; redirect targets drop their low bits.
  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of {pc, word} entries sitting between fetch and decode.
// Flush has priority over push and pop; a push is accepted when the queue
// is not full or when a pop frees the head in the same cycle.
module fetch_queue #(
  parameter int QDEPTH = 2,
  parameter int CW     = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [31:0]   push_pc,
  input  logic [31:0]   push_word,
  input  logic          pop,
  input  logic          flush,
  output logic [31:0]   head_pc,
  output logic [31:0]   head_word,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [31:0]   r_pc   [QDEPTH];
  logic [31:0]   r_word [QDEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(QDEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & ~flush & (~full | w_do_pop);
  assign head_pc   = r_pc[r_rd_ptr];
  assign head_word = r_word[r_rd_ptr];
  assign count     = r_count;

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage, written at the tail on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        r_pc[i]   <= '0;
        r_word[i] <= '0;
      end
    end else if (w_do_push) begin
      r_pc[r_wr_ptr]   <= push_pc;
      r_word[r_wr_ptr] <= push_word;
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: reads one byte per cycle from a byte-wide
// instruction memory, assembles big-endian 32-bit words and queues them
// for decode. A redirect flushes everything and restarts at the target.
//
// Decode handshake: a word transfers on a rising edge where inst_valid and
// inst_ready are both 1; while inst_valid=1 and inst_ready=0 the head word
// and PC hold steady; inst_ready with inst_valid=0 is ignored.
module fetch_prefetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int IMEM_AW = IMEM_AW_DEF,
  parameter int QDEPTH  = QDEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_rd,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [7:0]         imem_rdata,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst_word,
  output logic [31:0]        inst_pc,
  output logic [1:0]         q_count,
  output logic               dbg_state
);

  localparam int CW = $clog2(QDEPTH + 1);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  w_fetch_pc_nxt;
  logic [1:0]   r_byte_cnt;
  logic [1:0]   w_byte_cnt_nxt;
  logic [31:0]  r_asm;
  logic [31:0]  w_asm_nxt;
  logic [31:0]  w_word;
  logic         w_push;
  logic [31:0]  w_push_word;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic [31:0]  w_head_pc;
  logic [31:0]  w_head_word;
  logic [CW-1:0] w_count;

  // The final byte arrives combinationally, so the complete word is the
  // upper three assembled bytes plus the current read data.
  assign w_word = {r_asm[31:8], imem_rdata};
  assign w_pop  = inst_valid & inst_ready;

  fetch_queue #(
    .QDEPTH (QDEPTH),
    .CW     (CW)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_pc   (r_fetch_pc),
    .push_word (w_push_word),
    .pop       (w_pop),
    .flush     (redirect),
    .head_pc   (w_head_pc),
    .head_word (w_head_word),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  // State register for the fetch FSM and its datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_fetch_pc <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_asm      <= w_asm_nxt;
    end
  end

  // Next-state logic: redirect overrides everything; otherwise assemble
  // bytes and push the finished word, parking it in HOLD if no slot is free.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_byte_cnt_nxt = r_byte_cnt;
    w_asm_nxt      = r_asm;
    w_push         = 1'b0;
    w_push_word    = r_asm;
    if (redirect) begin
      w_state_nxt    = FETCH;
      w_fetch_pc_nxt = word_align(redirect_pc);
      w_byte_cnt_nxt = '0;
      w_asm_nxt      = '0;
    end else begin
      case (r_state)
        FETCH: begin
          case (r_byte_cnt)
            2'd0: begin
              w_asm_nxt[31:24] = imem_rdata;
              w_byte_cnt_nxt   = 2'd1;
            end
            2'd1: begin
              w_asm_nxt[23:16] = imem_rdata;
              w_byte_cnt_nxt   = 2'd2;
            end
            2'd2: begin
              w_asm_nxt[15:8] = imem_rdata;
              w_byte_cnt_nxt  = 2'd3;
            end
            default: begin
              if (!w_full || w_pop) begin
                w_push         = 1'b1;
                w_push_word    = w_word;
                w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                w_byte_cnt_nxt = '0;
              end else begin
                w_asm_nxt   = w_word;
                w_state_nxt = HOLD;
              end
            end
          endcase
        end
        HOLD: begin
          if (!w_full || w_pop) begin
            w_push         = 1'b1;
            w_push_word    = r_asm;
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            w_byte_cnt_nxt = '0;
            w_state_nxt    = FETCH;
          end
        end
        default: begin
          w_state_nxt = FETCH;
        end
      endcase
    end
  end

  // Outputs. The read strobe is gated by reset because the state register
  // rests in FETCH; the head fields read as zero whenever the queue is empty.
  assign imem_rd    = rst_n & (r_state == FETCH);
  assign imem_addr  = r_fetch_pc[IMEM_AW-1:0] + IMEM_AW'(r_byte_cnt);
  assign inst_valid = ~w_empty;
  assign inst_word  = w_empty ? 32'd0 : w_head_word;
  assign inst_pc    = w_empty ? 32'd0 : w_head_pc;
  assign q_count    = 2'(w_count);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: directed scenarios with hand-computed
// words, an expected queue of {pc, word} and a monitor that checks every
// word decode accepts.
module tb_fetch_prefetch_unit;
  import cpu_fetch_pkg::*;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_rd;
  logic [AW-1:0] imem_addr;
  logic [7:0]    imem_rdata;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [31:0]   inst_word;
  logic [31:0]   inst_pc;
  logic [1:0]    q_count;
  logic          dbg_state;

  logic [7:0]    mem [64];
  logic [63:0]   exp_q[$];
  logic [63:0]   mon_e;
  int            n_cmp = 0;
  int            n_err = 0;

  // Clock.
  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  fetch_prefetch_unit #(
    .IMEM_AW (AW),
    .QDEPTH  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_word   (inst_word),
    .inst_pc     (inst_pc),
    .q_count     (q_count),
    .dbg_state   (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d words still outstanding after %0d cycles, want 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // Monitor: compare every accepted word against the expected queue and
  // check the head holds steady across a stall.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_word  = '0;
  logic [31:0] prev_pc    = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && inst_valid && prev_stall) begin
        check("stall_word_stable", inst_word, prev_word);
        check("stall_pc_stable", inst_pc, prev_pc);
      end
      if (rst_n && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got pc %h word %h, want no word", inst_pc, inst_word);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_pc", inst_pc, mon_e[63:32]);
          check("out_word", inst_word, mon_e[31:0]);
        end
      end
      prev_stall = rst_n && inst_valid && !inst_ready;
      prev_word  = inst_word;
      prev_pc    = inst_pc;
    end
  end

  // Stimulus.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[0] = 8'h8C; mem[1] = 8'h22; mem[2] = 8'h00; mem[3] = 8'h04;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    neg();
    check("rst_imem_rd", 32'(imem_rd), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_word", inst_word, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_q_count", 32'(q_count), 32'd0);
    tick();

    // Reset fetch: bytes 0..3 over cycles 1-4, word visible in cycle 5.
    inst_ready = 1'b1;
    exp_q.push_back({32'h0000_0000, 32'h8C22_0004});
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      neg();
      check("t1_addr", 32'(imem_addr), 32'(c));
      check("t1_rd", 32'(imem_rd), 32'd1);
      check("t1_valid_low", 32'(inst_valid), 32'd0);
      tick();
    end
    neg();
    check("t1_valid_c5", 32'(inst_valid), 32'd1);
    check("t1_word_c5", inst_word, 32'h8C22_0004);
    check("t1_pc_c5", inst_pc, 32'd0);
    tick();
    inst_ready = 1'b0;
    wait_drain("t1_drain", 0);

    // Backpressure: queue fills, third word parks in HOLD, then drains.
    do_redirect(32'h0);
    exp_q.delete();
    exp_q.push_back({32'h0000_0000, 32'h8C22_0004});
    exp_q.push_back({32'h0000_0004, 32'hA1A0_A3A2});
    exp_q.push_back({32'h0000_0008, 32'hADAC_AFAE});
    neg();
    check("t2_valid_after_redirect", 32'(inst_valid), 32'd0);
    tick();
    repeat (18) tick();
    neg();
    check("t2_q_count_full", 32'(q_count), 32'd2);
    check("t2_state_hold", 32'(dbg_state), 32'(HOLD));
    check("t2_imem_rd_off", 32'(imem_rd), 32'd0);
    check("t2_head_word", inst_word, 32'h8C22_0004);
    check("t2_head_pc", inst_pc, 32'd0);
    tick();
    inst_ready = 1'b1;
    wait_drain("t2_drain", 20);
    inst_ready = 1'b0;

    // Redirect mid-word to an unaligned target.
    do_redirect(32'h0);
    tick();
    tick();
    neg();
    check("t3_addr_byte2", 32'(imem_addr), 32'd2);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_001B;
    tick();
    redirect = 1'b0;
    exp_q.delete();
    exp_q.push_back({32'h0000_0018, 32'hBDBC_BFBE});
    inst_ready = 1'b1;
    neg();
    check("t3_valid_low", 32'(inst_valid), 32'd0);
    check("t3_addr_target", 32'(imem_addr), 32'h18);
    wait_drain("t3_drain", 12);
    inst_ready = 1'b0;

    // Address wrap at the top of instruction memory.
    do_redirect(32'h0000_003C);
    exp_q.delete();
    exp_q.push_back({32'h0000_003C, 32'h9998_9B9A});
    exp_q.push_back({32'h0000_0040, 32'h8C22_0004});
    inst_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      neg();
      check("t4_addr", 32'(imem_addr), (c < 4) ? 32'(8'h3C + c) : 32'd0);
      tick();
    end
    wait_drain("t4_drain", 16);
    inst_ready = 1'b0;

    // Full queue with pop and push together, then redirect with a pop.
    do_redirect(32'h0);
    exp_q.delete();
    exp_q.push_back({32'h0000_0000, 32'h8C22_0004});
    exp_q.push_back({32'h0000_0004, 32'hA1A0_A3A2});
    repeat (11) tick();
    inst_ready = 1'b1;
    neg();
    check("t5_full_before", 32'(q_count), 32'd2);
    check("t5_state_fetch_b3", 32'(dbg_state), 32'(FETCH));
    tick();
    inst_ready = 1'b0;
    neg();
    check("t5_full_after_push_pop", 32'(q_count), 32'd2);
    check("t5_state_fetch", 32'(dbg_state), 32'(FETCH));
    check("t5_imem_rd_on", 32'(imem_rd), 32'd1);
    tick();
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    neg();
    tick();
    redirect   = 1'b0;
    inst_ready = 1'b0;
    neg();
    check("t5_q_count_flushed", 32'(q_count), 32'd0);
    check("t5_valid_flushed", 32'(inst_valid), 32'd0);
    wait_drain("t5_drain", 0);
    tick();

    // Asynchronous reset pulse in the middle of a word.
    do_redirect(32'h0);
    exp_q.delete();
    inst_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_imem_rd", 32'(imem_rd), 32'd0);
    check("t6_rst_imem_addr", 32'(imem_addr), 32'd0);
    check("t6_rst_valid", 32'(inst_valid), 32'd0);
    check("t6_rst_q_count", 32'(q_count), 32'd0);
    check("t6_rst_word", inst_word, 32'd0);
    check("t6_rst_pc", inst_pc, 32'd0);
    #2;
    rst_n = 1'b1;
    exp_q.push_back({32'h0000_0000, 32'h8C22_0004});
    neg();
    check("t6_restart_addr0", 32'(imem_addr), 32'd0);
    check("t6_restart_rd", 32'(imem_rd), 32'd1);
    tick();
    neg();
    check("t6_restart_addr1", 32'(imem_addr), 32'd1);
    wait_drain("t6_drain", 8);
    inst_ready = 1'b0;

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_unit.md
FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

Interface
REQ-001 SHALL have parameter IMEM_AW, default 6, meaning instruction memory byte-address width (64 bytes).
REQ-002 SHALL have parameter QDEPTH, default 2, meaning prefetch queue depth in words.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port imem_rd, output, 1, byte read strobe to instruction memory.
REQ-006 SHALL have port imem_addr, output, IMEM_AW, byte address to instruction memory.
REQ-007 SHALL have port imem_rdata, input, 8, byte returned combinationally in the same cycle as imem_addr.
REQ-008 SHALL have port redirect, input, 1, one-cycle pulse for a taken branch, jump, bvf or ben.
REQ-009 SHALL have port redirect_pc, input, 32, target PC, sampled when redirect=1.
REQ-010 SHALL have port inst_valid, output, 1, queue head holds a valid instruction.
REQ-011 SHALL have port inst_ready, input, 1, decode accepts the head word this cycle.
REQ-012 SHALL have port inst_word, output, 32, head instruction, big-endian assembled.
REQ-013 SHALL have port inst_pc, output, 32, PC of the head instruction.
REQ-014 SHALL have port q_count, output, 2, number of queued words (0..QDEPTH).

Function
REQ-015 SHALL hold a 32-bit fetch_pc, a 2-bit byte_cnt and a 32-bit assembly register.
REQ-016 SHALL run FSM states FETCH (reading bytes) and HOLD (word complete, queue full).
REQ-017 SHALL in FETCH drive imem_rd=1 and imem_addr=(fetch_pc[IMEM_AW-1:0]+byte_cnt) mod 2^IMEM_AW.
REQ-018 SHALL place byte_cnt 0,1,2,3 into assembly bits [31:24],[23:16],[15:8],[7:0].
REQ-019 SHALL on byte_cnt=3 push {assembled[31:8],imem_rdata} with tag fetch_pc if the queue is not full, or is full and pops this cycle; then fetch_pc+=4 (mod 2^32), byte_cnt=0, stay in FETCH.
REQ-020 SHALL otherwise at byte_cnt=3 latch the word, enter HOLD and drive imem_rd=0.
REQ-021 SHALL in HOLD push the held word in the first cycle a slot frees, then fetch_pc+=4 and return to FETCH.
REQ-022 SHALL pop the head when inst_valid=1 and inst_ready=1; inst_ready with inst_valid=0 has no effect.
REQ-023 SHALL keep inst_word and inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-024 SHALL give redirect highest priority: flush the queue, discard any partial or held word, set fetch_pc={redirect_pc[31:2],2'b00}, byte_cnt=0, state FETCH.
REQ-025 SHALL, on redirect coinciding with a pop, complete the pop and then flush; a coincident push is dropped.
REQ-026 SHALL drive inst_valid=0 in the cycle after a redirect.
REQ-027 SHALL, from reset release or redirect, present the first word with inst_valid=1 in the 5th cycle; steady throughput is one word per 4 cycles.
REQ-028 SHALL make q_count equal the number of occupied entries; inst_valid=(q_count!=0).

Reset
REQ-029 SHALL, while rst_n=0, force fetch_pc=0, byte_cnt=0, state FETCH, queue empty, assembly=0.
REQ-030 SHALL, while rst_n=0, drive imem_rd=0, imem_addr=0, inst_valid=0, inst_word=0, inst_pc=0, q_count=0.
REQ-031 SHALL, on rst_n deasserting mid-word, restart cleanly: the first read after release is address 0.

Structure
REQ-032 SHALL place IMEM_AW and QDEPTH defaults and the FETCH/HOLD encodings in shared package cpu_fetch_pkg.
REQ-033 SHALL implement the queue as sub-module fetch_queue (QDEPTH-entry FIFO of {pc,word} with push, pop, flush and count).

Verification
REQ-034 SHALL test reset fetch: mem[0..3]=8C,22,00,04, inst_ready=1 -> addresses 0,1,2,3 over cycles 1-4; cycle 5 inst_word=8C220004, inst_pc=0.
REQ-035 SHALL test backpressure: inst_ready=0 for 20 cycles -> q_count reaches 2, FSM enters HOLD, imem_rd=0 and words stay stable; releasing drains PCs 0,4,8 in order.
REQ-036 SHALL test redirect mid-word: redirect=1, redirect_pc=0x0000001B at byte_cnt=2 -> next cycle inst_valid=0 and imem_addr=0x18; first word delivered has inst_pc=0x18.
REQ-037 SHALL test wrap: redirect_pc=0x3C -> addresses 3C..3F then 00; second word inst_pc=0x40 with bytes read from mem[0..3].
REQ-038 SHALL test simultaneous events: queue full, pop and push in the same cycle -> q_count stays 2; redirect plus pop in the same cycle -> q_count=0 the next cycle.
REQ-039 SHALL test async reset mid-operation: rst_n low for 3 ns between clock edges -> outputs go to reset values immediately, and after release the fetch restarts at address 0.
